gcd_ctrl: RTL
=============

Name: gcd_ctrl

Overview:
- Control FSM for the 16-bit GCD subtract-and-compare datapath.
- Sequences two operands from a valid/ready stream into the datapath's A and B registers, then runs the subtract loop until A == B.
- Drives the datapath loads and mux selects; consumes its gt/ls/eq status.
- Guards against zero operands (the loop would never end) and against runaway iteration counts.
- On completion the GCD sits in datapath register A; done/err tell the downstream consumer when to read it.

Parameters:
- WIDTH, 16, operand width; must match the datapath bus.
- MAX_ITER, 65535, subtract-iteration limit before timeout.
- ITER_W, 16, iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  in  1  rising-edge clock, shared with the datapath.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present on data_in.
- in_ready  out  1  controller accepts an operand this cycle.
- data_in  in  WIDTH  operand bus, also wired to the datapath data_in; used here only for zero detection.
- gt  in  1  datapath: A > B.
- ls  in  1  datapath: A < B.
- eq  in  1  datapath: A == B.
- lda  out  1  load datapath register A.
- ldb  out  1  load datapath register B.
- sela  out  1  1: minuend = A; 0: minuend = B.
- selb  out  1  1: subtrahend = A; 0: subtrahend = B.
- sel_in  out  1  1: register input = data_in; 0: register input = difference.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; GCD valid in datapath A.
- err  out  1  one-cycle pulse; operation aborted.
- err_code  out  2  valid with err: 01 = zero operand, 10 = timeout; holds its value until the next err.
- iter_count  out  ITER_W  number of subtracts performed; cleared when operand A is accepted; holds after done/err.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - lda, ldb, sel_in, sela, selb, busy, done, err all 0; err_code 00; iter_count 0.
  - Datapath registers are not reset.
  - Reset mid-operation abandons the run with no done/err pulse.
- All datapath control outputs are combinational from the current state and gt/ls/eq/in_valid. Every output not listed for a state is 0.
- IDLE:
  - in_ready=1.
  - If in_valid: sel_in=1, lda=1; latch zero_a = (data_in==0); clear iter_count; go to LOAD_B.
- LOAD_B:
  - in_ready=1, busy=1.
  - If in_valid: sel_in=1, ldb=1. If zero_a or data_in==0, go to ERR with code 01; otherwise go to RUN.
  - Without in_valid the FSM waits indefinitely.
- RUN (in_ready=0, busy=1):
  - eq: no load; go to DONE.
  - gt: lda=1, sela=1, selb=0, sel_in=0 (A <= A-B); iter_count+1.
  - ls: ldb=1, sela=0, selb=1, sel_in=0 (B <= B-A); iter_count+1.
  - Timeout: if a subtract is issued while iter_count == MAX_ITER-1, the subtract still executes, iter_count becomes MAX_ITER, and the next state is ERR with code 10.
  - Status flags reflect the register values from the previous edge, so there is one compare/subtract per cycle.
  - If gt, ls and eq are all 0 or more than one is 1 (illegal), eq takes priority, then gt.
- DONE: done=1, busy=1 for one cycle; go to IDLE.
- ERR: err=1, busy=1 for one cycle; err_code updated on entry; go to IDLE.
- Latency: with in_valid held high, A is accepted at cycle 0 and B at cycle 1. The first RUN cycle is 2. done rises N+1 cycles after the first RUN cycle, where N = iteration count.
- in_valid is ignored in RUN, DONE and ERR; the source must hold the operand until in_ready.
- iter_count never wraps, because a timeout is taken first.

Test Plan:
- Operands 48 then 18, in_valid held high from cycle 0 -> subtract sequence (30,18), (12,18), (12,6), (6,6); iter_count=4; done pulse at cycle 7; datapath A=6; err stays 0.
- Operands 7 then 7 -> no loads in RUN; done at cycle 3; iter_count=0.
- Operands 0 then 5, and separately 9 then 0 -> err pulse at cycle 2 with err_code=01; no lda/ldb asserted after LOAD_B; done never asserts.
- MAX_ITER=8, operands 100 then 1 -> 8 subtracts with A ending at 92; err with err_code=10; iter_count=8; next operand pair is accepted normally.
- rst asserted for one cycle during RUN of 48/18 -> next cycle is IDLE, in_ready=1, all control outputs 0, no done; a following 21/14 pair gives done with datapath A=7.
- Operand A accepted, then in_valid low for 5 cycles before B arrives -> FSM stays in LOAD_B with busy=1 and ldb=0 until B is accepted; result is still correct.

Source files
------------

// File: rtl/gcd_ctrl_if.sv
// Operand stream between an upstream source and the GCD controller.
// The operand bus is also wired to the datapath register inputs.
interface gcd_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;

    modport master (output in_valid, output data_in, input in_ready);
    modport slave  (input in_valid, input data_in, output in_ready);
endinterface

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtract-and-compare GCD datapath: loads A and B from the
// operand stream, iterates until A == B, and reports done, zero-operand or timeout.
module gcd_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 65535,
    parameter int ITER_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    gcd_ctrl_if.slave         in_if,
    input  logic              gt,
    input  logic              ls,
    input  logic              eq,
    output logic              lda,
    output logic              ldb,
    output logic              sela,
    output logic              selb,
    output logic              sel_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_B = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [1:0]        ERR_ZERO    = 2'b01;
    localparam logic [1:0]        ERR_TIMEOUT = 2'b10;
    localparam logic [ITER_W-1:0] ITER_LAST   = ITER_W'(MAX_ITER - 1);

    state_t              state_q, state_d;
    logic                zero_a_q, zero_a_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                data_zero;

    assign data_zero = (in_if.data_in == {WIDTH{1'b0}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            zero_a_q   <= 1'b0;
            iter_q     <= '0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            zero_a_q   <= zero_a_d;
            iter_q     <= iter_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        zero_a_d        = zero_a_q;
        iter_d          = iter_q;
        err_code_d      = err_code_q;
        in_if.in_ready  = 1'b0;
        lda             = 1'b0;
        ldb             = 1'b0;
        sela            = 1'b0;
        selb            = 1'b0;
        sel_in          = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        err             = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_if.in_ready = 1'b1;
                if (in_if.in_valid) begin
                    sel_in   = 1'b1;
                    lda      = 1'b1;
                    zero_a_d = data_zero;
                    iter_d   = '0;
                    state_d  = LOAD_B;
                end
            end
            LOAD_B: begin
                in_if.in_ready = 1'b1;
                busy           = 1'b1;
                if (in_if.in_valid) begin
                    sel_in = 1'b1;
                    ldb    = 1'b1;
                    // A zero operand would make the subtract loop spin forever.
                    if (zero_a_q || data_zero) begin
                        err_code_d = ERR_ZERO;
                        state_d    = ERR;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (eq) begin
                    state_d = DONE;
                end else if (gt || ls) begin
                    if (gt) begin
                        lda  = 1'b1;
                        sela = 1'b1;
                    end else begin
                        ldb  = 1'b1;
                        selb = 1'b1;
                    end
                    iter_d = iter_q + 1'b1;
                    // The final permitted subtract still executes before aborting.
                    if (iter_q == ITER_LAST) begin
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ERR;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                busy    = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_code   = err_code_q;
    assign iter_count = iter_q;

endmodule
